// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
//
// Purpose:
//    General-purpose register file fed by the pipeline writeback stage.
//    It holds 2**ADDR_W registers of DATA_W bits each, and register 0 always
//    reads as zero. Two combinational decode read ports forward a write
//    that commits in the same cycle. A registered debug read port has no
//    forwarding. For bring-up, the block keeps a commit trace (last
//    register and value written) and a saturating count of committed writes.
//
// Ports:
//    clk_i        system clock; all state changes on its rising edge
//    rst_i        synchronous active-high reset
//    wb_wd_i      writeback write enable
//    wb_wreg_i    writeback destination register index
//    wb_wdata_i   writeback data
//    re1_i        read enable, port 1
//    raddr1_i     read index, port 1
//    rdata1_o     read data, port 1 (combinational, write-bypassed)
//    re2_i        read enable, port 2
//    raddr2_i     read index, port 2
//    rdata2_o     read data, port 2 (combinational, write-bypassed)
//    dbg_addr_i   debug read index
//    dbg_data_o   debug read data, one cycle latency, no bypass
//    last_wreg_o  index of the most recent committed write
//    last_wdata_o data of the most recent committed write
//    last_valid_o at least one write has committed since reset
//    wr_count_o   number of committed writes, saturating
// ---------------------------------------------------------------------------
module regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wb_wd_i,
   input  logic [ADDR_W-1:0] wb_wreg_i,
   input  logic [DATA_W-1:0] wb_wdata_i,
   input  logic              re1_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   output logic [DATA_W-1:0] rdata1_o,
   input  logic              re2_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata2_o,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o,
   output logic [ADDR_W-1:0] last_wreg_o,
   output logic [DATA_W-1:0] last_wdata_o,
   output logic              last_valid_o,
   output logic [CNT_W-1:0]  wr_count_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
   logic [ADDR_W-1:0] last_wreg_q, last_wreg_d;
   logic [DATA_W-1:0] last_wdata_q, last_wdata_d;
   logic              last_valid_q, last_valid_d;
   logic [CNT_W-1:0]  wr_count_q, wr_count_d;
   logic              commit;

   // A write counts only when it is enabled, does not target r0, and does
   // not collide with reset. Everything that observes a write uses this one
   // qualifier: the array, the bypass, the trace and the counter.
   assign commit = wb_wd_i && (wb_wreg_i != '0) && !rst_i;

   // Read ports are resolved in priority order: reset, disabled port, r0,
   // same-cycle write forwarding, and finally the stored register.
   always_comb begin
      rdata1_o = '0;
      if (!rst_i && re1_i && (raddr1_i != '0)) begin
         if (commit && (raddr1_i == wb_wreg_i)) begin
            rdata1_o = wb_wdata_i;
         end else begin
            rdata1_o = regs_q[raddr1_i];
         end
      end
   end

   always_comb begin
      rdata2_o = '0;
      if (!rst_i && re2_i && (raddr2_i != '0)) begin
         if (commit && (raddr2_i == wb_wreg_i)) begin
            rdata2_o = wb_wdata_i;
         end else begin
            rdata2_o = regs_q[raddr2_i];
         end
      end
   end

   // Next-state logic for the debug port, trace and counter. The debug port
   // samples the array before this cycle's write lands, so a write to the
   // same index shows up one cycle later. The counter stops at all-ones so
   // long runs never wrap to a misleading small value.
   always_comb begin
      dbg_data_d   = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];
      last_wreg_d  = last_wreg_q;
      last_wdata_d = last_wdata_q;
      last_valid_d = last_valid_q;
      wr_count_d   = wr_count_q;
      if (commit) begin
         last_wreg_d  = wb_wreg_i;
         last_wdata_d = wb_wdata_i;
         last_valid_d = 1'b1;
         if (wr_count_q != '1) begin
            wr_count_d = wr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Register array. Reset clears every entry, including r0, so the zero
   // register never holds anything but zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (commit) begin
         regs_q[wb_wreg_i] <= wb_wdata_i;
      end
   end

   // Debug, trace and counter state. Reset takes priority over any write
   // presented in the same cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dbg_data_q   <= '0;
         last_wreg_q  <= '0;
         last_wdata_q <= '0;
         last_valid_q <= 1'b0;
         wr_count_q   <= '0;
      end else begin
         dbg_data_q   <= dbg_data_d;
         last_wreg_q  <= last_wreg_d;
         last_wdata_q <= last_wdata_d;
         last_valid_q <= last_valid_d;
         wr_count_q   <= wr_count_d;
      end
   end

   assign dbg_data_o   = dbg_data_q;
   assign last_wreg_o  = last_wreg_q;
   assign last_wdata_o = last_wdata_q;
   assign last_valid_o = last_valid_q;
   assign wr_count_o   = wr_count_q;

endmodule

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile
//
// Self-checking bench for regfile. A behavioural model (a plain array plus
// trace and count variables) tracks what the register file should hold.
// Every cycle compares both read ports, the debug port, the trace outputs and
// the counters against it. A second instance with a 4-bit counter exercises
// counter saturation on the same stimulus.
// ---------------------------------------------------------------------------
module tb_regfile;

   logic        clk;
   logic        rst;
   logic        wbWd;
   logic [4:0]  wbWreg;
   logic [31:0] wbWdata;
   logic        re1, re2;
   logic [4:0]  raddr1, raddr2, dbgAddr;
   logic [31:0] rdata1, rdata2, dbgData, lastWdata;
   logic [4:0]  lastWreg;
   logic        lastValid;
   logic [15:0] wrCount;

   logic [31:0] rdata1S, rdata2S, dbgDataS, lastWdataS;
   logic [4:0]  lastWregS;
   logic        lastValidS;
   logic [3:0]  wrCountS;

   int checks = 0;
   int errors = 0;

   logic [31:0] model [32];
   logic [4:0]  mLastWreg;
   logic [31:0] mLastWdata;
   logic        mLastValid;
   int          mCount;
   int          mCountS;

   regfile dut (
      .clk_i(clk), .rst_i(rst),
      .wb_wd_i(wbWd), .wb_wreg_i(wbWreg), .wb_wdata_i(wbWdata),
      .re1_i(re1), .raddr1_i(raddr1), .rdata1_o(rdata1),
      .re2_i(re2), .raddr2_i(raddr2), .rdata2_o(rdata2),
      .dbg_addr_i(dbgAddr), .dbg_data_o(dbgData),
      .last_wreg_o(lastWreg), .last_wdata_o(lastWdata),
      .last_valid_o(lastValid), .wr_count_o(wrCount)
   );

   regfile #(.CNT_W(4)) dutSmall (
      .clk_i(clk), .rst_i(rst),
      .wb_wd_i(wbWd), .wb_wreg_i(wbWreg), .wb_wdata_i(wbWdata),
      .re1_i(re1), .raddr1_i(raddr1), .rdata1_o(rdata1S),
      .re2_i(re2), .raddr2_i(raddr2), .rdata2_o(rdata2S),
      .dbg_addr_i(dbgAddr), .dbg_data_o(dbgDataS),
      .last_wreg_o(lastWregS), .last_wdata_o(lastWdataS),
      .last_valid_o(lastValidS), .wr_count_o(wrCountS)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and on a mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives every input of the design in one call.
   task automatic applyStimulus(input logic r, input logic wd, input logic [4:0] wreg,
                                input logic [31:0] wdata, input logic e1, input logic [4:0] a1,
                                input logic e2, input logic [4:0] a2, input logic [4:0] da);
      rst = r; wbWd = wd; wbWreg = wreg; wbWdata = wdata;
      re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2; dbgAddr = da;
   endtask

   function automatic bit commitNow();
      return wbWd && (wbWreg != 5'd0) && !rst;
   endfunction

   // Expected combinational read value, straight from the port priority rules.
   function automatic logic [31:0] expRead(input logic e, input logic [4:0] a);
      if (rst || !e || a == 5'd0) return 32'd0;
      if (commitNow() && a == wbWreg) return wbWdata;
      return model[a];
   endfunction

   // Runs one clock: checks read ports mid-cycle, advances the model at the
   // edge, then checks every registered output just after the edge.
   task automatic clockCycle();
      logic [31:0] expDbg;
      bit          c;
      @(negedge clk);
      checkOutput("rdata1", rdata1, expRead(re1, raddr1));
      checkOutput("rdata2", rdata2, expRead(re2, raddr2));
      expDbg = (dbgAddr == 5'd0) ? 32'd0 : model[dbgAddr];
      c = commitNow();
      @(posedge clk);
      #1;
      if (rst) begin
         for (int i = 0; i < 32; i++) model[i] = 32'd0;
         mLastWreg = 5'd0; mLastWdata = 32'd0; mLastValid = 1'b0;
         mCount = 0; mCountS = 0;
         expDbg = 32'd0;
      end else if (c) begin
         model[wbWreg] = wbWdata;
         mLastWreg = wbWreg; mLastWdata = wbWdata; mLastValid = 1'b1;
         if (mCount < 65535) mCount++;
         if (mCountS < 15) mCountS++;
      end
      checkOutput("dbg_data", dbgData, expDbg);
      checkOutput("last_wreg", {27'd0, lastWreg}, {27'd0, mLastWreg});
      checkOutput("last_wdata", lastWdata, mLastWdata);
      checkOutput("last_valid", {31'd0, lastValid}, {31'd0, mLastValid});
      checkOutput("wr_count", {16'd0, wrCount}, mCount);
      checkOutput("wr_count_small", {28'd0, wrCountS}, mCountS);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      mLastWreg = 5'd0; mLastWdata = 32'd0; mLastValid = 1'b0;
      mCount = 0; mCountS = 0;

      // Reset, then read with both ports enabled.
      applyStimulus(1, 0, 0, 0, 1, 3, 1, 31, 0);
      clockCycle();
      applyStimulus(0, 0, 0, 0, 1, 3, 1, 31, 0);
      clockCycle();
      checkOutput("reset_rdata1", rdata1, 32'd0);
      checkOutput("reset_count", {16'd0, wrCount}, 32'd0);

      // Write r5, then read it back and inspect the trace.
      applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      clockCycle();
      applyStimulus(0, 0, 0, 0, 1, 5, 0, 0, 0);
      #1;
      checkOutput("read_r5", rdata1, 32'hDEADBEEF);
      checkOutput("trace_wreg", {27'd0, lastWreg}, 32'd5);
      checkOutput("trace_count", {16'd0, wrCount}, 32'd1);
      clockCycle();

      // Same-cycle bypass on both ports, and the debug port lagging by one.
      applyStimulus(0, 1, 7, 32'h12345678, 1, 7, 1, 7, 7);
      #1;
      checkOutput("bypass1", rdata1, 32'h12345678);
      checkOutput("bypass2", rdata2, 32'h12345678);
      clockCycle();
      checkOutput("dbg_old", dbgData, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7);
      clockCycle();
      checkOutput("dbg_new", dbgData, 32'h12345678);

      // Write to r0 is discarded; disabled write is ignored; disabled port reads 0.
      applyStimulus(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
      clockCycle();
      checkOutput("r0_count", {16'd0, wrCount}, 32'd2);
      checkOutput("r0_trace", {27'd0, lastWreg}, 32'd7);
      applyStimulus(0, 0, 9, 32'h0000AAAA, 0, 0, 0, 0, 9);
      clockCycle();
      applyStimulus(0, 0, 0, 0, 0, 5, 1, 9, 0);
      #1;
      checkOutput("re1_off", rdata1, 32'd0);
      checkOutput("r9_unwritten", rdata2, 32'd0);
      clockCycle();

      // Reset colliding with a write.
      applyStimulus(1, 1, 4, 32'h55, 1, 4, 0, 0, 0);
      clockCycle();
      applyStimulus(0, 0, 0, 0, 1, 4, 0, 0, 4);
      clockCycle();
      checkOutput("collide_r4", rdata1, 32'd0);

      // Fill r1..r31 with their index, read all back, then reset mid-stream.
      for (int i = 1; i < 32; i++) begin
         applyStimulus(0, 1, 5'(i), 32'(i), 1, 5'(i - 1), 1, 5'(i), 5'(i - 1));
         clockCycle();
      end
      for (int i = 0; i < 32; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 5'(i), 1, 5'(31 - i), 5'(i));
         clockCycle();
      end
      applyStimulus(1, 1, 12, 32'hCAFE, 1, 12, 1, 12, 12);
      clockCycle();
      for (int i = 0; i < 32; i++) begin
         applyStimulus(0, 0, 0, 0, 1, 5'(i), 1, 5'(i), 5'(i));
         clockCycle();
      end
      checkOutput("fill_reset_count", {16'd0, wrCount}, 32'd0);

      // Twenty commits to r1: the 4-bit counter stops at 15.
      for (int k = 0; k < 20; k++) begin
         applyStimulus(0, 1, 1, 32'h100 + 32'(k), 1, 1, 0, 0, 1);
         clockCycle();
      end
      checkOutput("sat_small", {28'd0, wrCountS}, 32'd15);
      checkOutput("sat_wide", {16'd0, wrCount}, 32'd20);
      checkOutput("sat_last", lastWdataS, 32'h113);

      // Randomised traffic, with reads often aimed at the write target.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] w;
         w = 5'($urandom_range(0, 31));
         applyStimulus(($urandom_range(0, 49) == 0),
                       1'($urandom_range(0, 1)), w, $urandom(),
                       ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 2) == 0) ? w : 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 2) == 0) ? w : 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)));
         clockCycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file that consumes the writeback interface (wb_wd, wb_wreg, wb_wdata) produced at the end of the pipeline.
- Holds 32 x 32-bit architectural registers; r0 is hardwired to zero.
- Serves two decode-stage read ports plus one debug read port.
- Writes land on the clock edge; same-cycle write-to-read bypass is provided.
- Keeps a commit trace (last written register/value) and a saturating count of committed writes for bring-up and verification.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register index width; depth is 2**ADDR_W.
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, synchronous and active-high, sampled on posedge clk.
- wb_wd  input  1  write enable from writeback.
- wb_wreg  input  ADDR_W  destination register index.
- wb_wdata  input  DATA_W  write data.
- re1  input  1  read enable, port 1.
- raddr1  input  ADDR_W  read index, port 1.
- rdata1  output  DATA_W  read data, port 1 (combinational).
- re2  input  1  read enable, port 2.
- raddr2  input  ADDR_W  read index, port 2.
- rdata2  output  DATA_W  read data, port 2 (combinational).
- dbg_addr  input  ADDR_W  debug read index.
- dbg_data  output  DATA_W  debug read data (registered, 1-cycle latency).
- last_wreg  output  ADDR_W  index of most recent committed write.
- last_wdata  output  DATA_W  data of most recent committed write.
- last_valid  output  1  at least one write has committed since reset.
- wr_count  output  CNT_W  number of committed writes, saturating.

Behaviour:
- Commit condition: wb_wd=1 and wb_wreg!=0 and rst=0. On posedge clk, regs[wb_wreg] <= wb_wdata.
- Writes to r0 are discarded: no array update, no trace update, no count increment.
- Reset (rst=1 at posedge):
  - all 32 registers cleared to 0;
  - dbg_data=0, last_wreg=0, last_wdata=0, last_valid=0, wr_count=0.
  - Reset wins over a simultaneous write. A reset asserted mid-stream discards the write presented in that cycle.
- Read ports 1 and 2 (identical, independent), priority order:
  1. rst=1 -> 0;
  2. re=0 -> 0;
  3. raddr=0 -> 0;
  4. commit condition true and raddr==wb_wreg -> wb_wdata (bypass, same cycle);
  5. otherwise regs[raddr].
- Both ports may read the same index, including the one being written; both then return the bypassed value.
- Debug port:
  - dbg_data <= regs[dbg_addr] on each posedge; no bypass.
  - A write and a debug read of the same index in the same cycle returns the old value; the new value appears one cycle later.
  - dbg_addr=0 always yields 0.
- Trace: on each commit, last_wreg <= wb_wreg, last_wdata <= wb_wdata, last_valid <= 1. All three are otherwise held.
- Counter: wr_count increments by 1 per commit and saturates at 2**CNT_W-1 (no wrap).
- Invalid-write squash: if wb_wd=0, wb_wreg/wb_wdata are ignored regardless of value.
- No X propagation: every output is a defined value at all times after the first reset edge.

Test Plan:
- Reset then read: assert rst 1 cycle, re1=re2=1, raddr1=3, raddr2=31 -> rdata1=0, rdata2=0, wr_count=0, last_valid=0.
- Write then read: wb_wd=1, wb_wreg=5, wb_wdata=0xDEADBEEF for 1 cycle, then raddr1=5 next cycle -> rdata1=0xDEADBEEF, last_wreg=5, last_wdata=0xDEADBEEF, last_valid=1, wr_count=1.
- Bypass: same cycle as write wreg=7, data=0x12345678, raddr1=raddr2=7, re1=re2=1 -> both ports 0x12345678 combinationally in that cycle. Same stimulus with dbg_addr=7 -> dbg_data=old value (0) next edge, 0x12345678 the edge after.
- r0 and disabled writes:
  - wb_wd=1, wb_wreg=0, data=0xFFFFFFFF -> raddr1=0 returns 0, wr_count unchanged, trace unchanged.
  - wb_wd=0, wreg=9, data=0xAAAA -> reg 9 stays 0.
  - re1=0 with raddr1=5 holding 0xDEADBEEF -> rdata1=0.
- Reset collision and mid-stream reset: rst=1 with wb_wd=1, wreg=4, data=0x55 -> reg 4 reads 0 after reset. Fill regs 1..31 with value=index, then assert rst -> all read 0 and wr_count=0.
- Counter saturation (CNT_W=4 override): perform 20 commits to reg 1 -> wr_count stops at 15. last_wdata equals the 20th write's data.
